mux_select_sequencer: RTL and testbench
=======================================

// Module: mux_select_sequencer
// PURPOSE
//   Upstream driver for the 7-to-1 bit-select mux on the board top level.
//   On start, latches a 7-bit pattern and steps the 3-bit select through 0..len-1.
//   Each select value is held for TICK_DIV clocks, which serialises the pattern
//   LSB-first onto the mux output (LEDR[0]).
//   Provides busy/valid status and a one-cycle done pulse so that later stages
//   can chain serial transfers.
// PARAMETERS
//   TICK_DIV   25_000_000  clocks per select step (0.5 s at 50 MHz); must be >= 1
//   DIV_WIDTH  25          divider counter width; must satisfy 2**DIV_WIDTH >= TICK_DIV
// PORTS
//   CLOCK_50    in   1  system clock, rising edge
//   resetn      in   1  asynchronous active-low reset
//   start       in   1  synchronous request; sampled only in IDLE
//   pattern_in  in   7  data to serialise; bit i is emitted while s==i
//   len         in   3  number of bits to emit, 1..7; value 0 means 7
//   x           out  7  latched pattern, to mux data inputs
//   s           out  3  mux select, always within 0..6
//   valid       out  1  high while s/x are presenting a live bit
//   busy        out  1  high from start acceptance until the done cycle
//   done        out  1  one-cycle pulse after the last bit period
// BEHAVIOUR
//   Reset (asynchronous, any state)
//     - state=IDLE; x=0, s=0, valid=0, busy=0, done=0; divider=0; len_r=0.
//     - Takes effect immediately, including mid-RUN. No partial transfer resumes.
//   FSM states: IDLE, RUN, DONE. All registers update on CLOCK_50 rising edge.
//   IDLE
//     - start=1 at edge k: x<=pattern_in; len_r<=(len==0)?7:len; s<=0;
//       divider<=0; valid<=1; busy<=1; go to RUN.
//     - start=0: hold. x retains the last pattern; s=0.
//   RUN
//     - divider counts 0..TICK_DIV-1. Terminal count is the tick.
//     - Tick with s<len_r-1: s<=s+1; divider<=0.
//     - Tick with s==len_r-1: valid<=0; busy<=0; done<=1; s<=0; go to DONE.
//     - start is ignored. x and len_r are frozen.
//   DONE
//     - done=1 for exactly one cycle, then done<=0 and go to IDLE.
//     - start asserted in DONE is ignored. A start on the following cycle (IDLE) is accepted.
//   Timing
//     - Each s value is held for exactly TICK_DIV cycles.
//     - valid is high for len_r*TICK_DIV cycles.
//     - done is asserted len_r*TICK_DIV cycles after the accepting edge.
//     - TICK_DIV=1: s advances every cycle.
//   Arithmetic
//     - s never exceeds 6, so the mux default branch is unreachable.
//     - divider never exceeds TICK_DIV-1 and never wraps through 2**DIV_WIDTH.
//     - len_r is 3 bits and holds 1..7.
//   Outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING (sim with TICK_DIV=4, DIV_WIDTH=3)
//   1. Reset: resetn=0 -> x=0, s=0, valid/busy/done=0 with no clock edge.
//      Release and hold start=0 -> outputs stay 0.
//   2. pattern_in=7'b1010011, len=0, 1-cycle start -> s=0..6, each held 4 cycles;
//      mux out 1,1,0,0,1,0,1; valid high 28 cycles; done pulse on cycle 29.
//   3. len=3, pattern_in=7'b0000101 -> s=0,1,2 (bits 1,0,1); done 12 cycles after
//      start; s=0 and busy=0 in the done cycle.
//   4. During RUN at s=2, pulse start with pattern_in=7'h7F -> x unchanged,
//      sequence and done timing unaffected.
//   5. resetn=0 mid-RUN at s=3 -> immediate clear. After release, stays IDLE
//      until next start; next transfer begins at s=0.
//   6. start held high continuously, len=1 -> one accepted transfer of 4 cycles,
//      done pulse, start ignored in DONE, re-accepted the next cycle.
//      Repeat with TICK_DIV=1: s steps every cycle.

Source files
------------

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: serialises a latched 7-bit pattern LSB-first by stepping a 3-bit mux select
//   CLOCK_50    clock, rising edge
//   resetn      asynchronous active-low reset
//   start       transfer request, sampled only while idle
//   pattern_in  data to serialise; bit i is emitted while s==i
//   len         bits to emit, 1..7 (0 means 7)
//   x           latched pattern for the mux data inputs
//   s           mux select, 0..6
//   valid       s/x present a live bit
//   busy        from start acceptance until the done cycle
//   done        one-cycle pulse after the last bit period
module mux_select_sequencer #(
    parameter int TICK_DIV  = 25_000_000,
    parameter int DIV_WIDTH = 25
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [6:0] pattern_in,
    input  logic [2:0] len,
    output logic [6:0] x,
    output logic [2:0] s,
    output logic       valid,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(TICK_DIV - 1);
    state_t               state;
    logic [DIV_WIDTH-1:0] divider;
    logic [2:0]           len_r;
    logic                 tick;
    assign tick = divider == DIV_LAST;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            x       <= '0;
            s       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divider <= '0;
            len_r   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x       <= pattern_in;
                    len_r   <= (len == 3'd0) ? 3'd7 : len;
                    s       <= '0;
                    divider <= '0;
                    valid   <= 1'b1;
                    busy    <= 1'b1;
                    state   <= RUN;
                end
                RUN: if (!tick) begin
                    divider <= divider + DIV_WIDTH'(1);
                end else if (s == len_r - 3'd1) begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    s       <= '0;
                    divider <= '0;
                    state   <= DONE;
                end else begin
                    s       <= s + 3'd1;
                    divider <= '0;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer: directed checks of the select sequencer at TICK_DIV=4 and TICK_DIV=1
module tb_mux_select_sequencer;
    logic       clk = 1'b0, resetn = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [6:0] pattern_in = '0;
    logic [2:0] len = '0;
    logic [6:0] x1, x2;
    logic [2:0] s1, s2;
    logic       valid1, busy1, done1, valid2, busy2, done2;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    mux_select_sequencer #(.TICK_DIV(4), .DIV_WIDTH(3)) dut1 (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .pattern_in(pattern_in), .len(len),
        .x(x1), .s(s1), .valid(valid1), .busy(busy1), .done(done1));

    mux_select_sequencer #(.TICK_DIV(1), .DIV_WIDTH(1)) dut2 (
        .CLOCK_50(clk), .resetn(resetn), .start(start2), .pattern_in(pattern_in), .len(len),
        .x(x2), .s(s2), .valid(valid2), .busy(busy2), .done(done2));

    function automatic logic [12:0] st1();
        return {x1, s1, valid1, busy1, done1};
    endfunction

    function automatic logic [12:0] st2();
        return {x2, s2, valid2, busy2, done2};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic xfer(input logic [6:0] pat, input logic [2:0] l, input bit inj);
        int n;
        n = (l == 3'd0) ? 7 : int'(l);
        pattern_in = pat;
        len = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n * 4; i++) begin
            if (inj && i == 8) begin
                start = 1'b1;
                pattern_in = 7'h7F;
            end else if (inj && i == 9) begin
                start = 1'b0;
                pattern_in = pat;
            end
            chk("run", st1(), {pat, 3'(i / 4), 3'b110});
            chk("mux", 13'(x1[s1]), 13'(pat[i / 4]));
            @(negedge clk);
        end
        chk("done", st1(), {pat, 3'd0, 3'b001});
        @(negedge clk);
        chk("idle_after", st1(), {pat, 3'd0, 3'b000});
    endtask

    initial begin
        logic [6:0] p;
        // reset with no clock edge
        #1 resetn = 1'b0;
        #1;
        chk("rst1", st1(), 13'd0);
        chk("rst2", st2(), 13'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_hold", st1(), 13'd0);
        end
        // full 7-bit transfer, then len=3, then start injected mid-run
        xfer(7'b1010011, 3'd0, 1'b0);
        xfer(7'b0000101, 3'd3, 1'b0);
        xfer(7'b0110101, 3'd0, 1'b1);
        // reset mid-run at s=3
        p = 7'b0110110;
        pattern_in = p;
        len = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_s3", st1(), {p, 3'd3, 3'b110});
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst", st1(), 13'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", st1(), 13'd0);
        end
        xfer(p, 3'd5, 1'b0);
        // start held high, len=1, TICK_DIV=4
        p = 7'b0000001;
        pattern_in = p;
        len = 3'd1;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("held_run", st1(), {p, 3'd0, 3'b110});
            @(negedge clk);
        end
        chk("held_done", st1(), {p, 3'd0, 3'b001});
        @(negedge clk);
        chk("held_ignored", st1(), {p, 3'd0, 3'b000});
        @(negedge clk);
        chk("held_reaccept", st1(), {p, 3'd0, 3'b110});
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_done2", st1(), {p, 3'd0, 3'b001});
        // start held high, len=3, TICK_DIV=1
        p = 7'b1010011;
        pattern_in = p;
        len = 3'd3;
        start2 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("fast_run", st2(), {p, 3'(i), 3'b110});
            chk("fast_mux", 13'(x2[s2]), 13'(p[i]));
            @(negedge clk);
        end
        chk("fast_done", st2(), {p, 3'd0, 3'b001});
        @(negedge clk);
        chk("fast_ignored", st2(), {p, 3'd0, 3'b000});
        @(negedge clk);
        chk("fast_reaccept", st2(), {p, 3'd0, 3'b110});
        start2 = 1'b0;
        @(negedge clk);
        chk("fast_s1", st2(), {p, 3'd1, 3'b110});
        @(negedge clk);
        chk("fast_s2", st2(), {p, 3'd2, 3'b110});
        @(negedge clk);
        chk("fast_done2", st2(), {p, 3'd0, 3'b001});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
